// File: rtl/dds_pkg.sv
// Shared DDS definitions: tuning-word width, sweep mode and sweep FSM encodings.
package dds_pkg;

  localparam int unsigned DDS_PW = 32;

  typedef enum logic [1:0] {
    SINGLE   = 2'd0,
    REPEAT   = 2'd1,
    TRIANGLE = 2'd2
  } sweep_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sweep_state_e;

  // Host mode field to sweep mode; the reserved code runs as a single sweep.
  function automatic sweep_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return REPEAT;
      2'd2:    return TRIANGLE;
      default: return SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/sweep_step_clamp.sv
// One sweep step: freq +/- step, clamped so an overshoot lands exactly on target.
module sweep_step_clamp
  import dds_pkg::*;
#(
  parameter int unsigned PW = DDS_PW
) (
  input  logic signed [PW-1:0] freq_i,
  input  logic        [PW-1:0] step_i,
  input  logic signed [PW-1:0] target_i,
  input  logic                 dir_i,
  output logic signed [PW-1:0] nxt_o,
  output logic                 reached_o
);

  // Two guard bits keep freq +/- a full-range unsigned step from wrapping.
  logic signed [PW+1:0] f_ext, t_ext, s_ext, sum;
  logic                 overshoot;

  // Step, compare against the leg target, clamp.
  always_comb begin
    f_ext     = {{2{freq_i[PW-1]}}, freq_i};
    t_ext     = {{2{target_i[PW-1]}}, target_i};
    s_ext     = {2'b00, step_i};
    sum       = dir_i ? (f_ext + s_ext) : (f_ext - s_ext);
    overshoot = dir_i ? (sum >= t_ext) : (sum <= t_ext);
    nxt_o     = overshoot ? target_i : sum[PW-1:0];
    reached_o = (freq_i == target_i);
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Chirp sequencer feeding the DDS: steps the tuning word from start toward stop,
// holding each point for a dwell, in single, repeating or triangle modes.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned PW  = DDS_PW,
  parameter int unsigned DWW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           mode,
  input  logic signed [PW-1:0] start_freq,
  input  logic signed [PW-1:0] stop_freq,
  input  logic        [PW-1:0] step,
  input  logic       [DWW-1:0] dwell,
  output logic signed [PW-1:0] freq,
  output logic                 freq_en,
  output logic                 busy,
  output logic                 dir,
  output logic                 done,
  output logic                 err
);

  sweep_state_e         state_q, state_d;
  sweep_mode_e          mode_q, mode_d;
  logic signed [PW-1:0] sfreq_q, sfreq_d, efreq_q, efreq_d;
  logic signed [PW-1:0] tgt_q, tgt_d, freq_q, freq_d;
  logic        [PW-1:0] step_q, step_d;
  logic       [DWW-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
  logic                 dir_q, dir_d, done_q, done_d, err_q, err_d;

  logic signed [PW-1:0] adv_nxt, turn_nxt, tgt_swap;
  logic                 leg_end, turn_reached_unused;
  logic       [DWW-1:0] dwell_eff;

  assign dwell_eff = (dwell == '0) ? DWW'(1) : dwell;
  assign tgt_swap  = (tgt_q == efreq_q) ? sfreq_q : efreq_q;

  sweep_step_clamp #(.PW(PW)) u_adv (
    .freq_i    (freq_q),
    .step_i    (step_q),
    .target_i  (tgt_q),
    .dir_i     (dir_q),
    .nxt_o     (adv_nxt),
    .reached_o (leg_end)
  );

  // Triangle turnaround: first point of the reversed leg, so the endpoint is not repeated.
  sweep_step_clamp #(.PW(PW)) u_turn (
    .freq_i    (freq_q),
    .step_i    (step_q),
    .target_i  (tgt_swap),
    .dir_i     (~dir_q),
    .nxt_o     (turn_nxt),
    .reached_o (turn_reached_unused)
  );

  // State, config and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= SINGLE;
      sfreq_q <= '0;
      efreq_q <= '0;
      tgt_q   <= '0;
      freq_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sfreq_q <= sfreq_d;
      efreq_q <= efreq_d;
      tgt_q   <= tgt_d;
      freq_q  <= freq_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state: config latch on start, dwell countdown, advance and leg-end handling.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sfreq_d = sfreq_q;
    efreq_d = efreq_q;
    tgt_d   = tgt_q;
    freq_d  = freq_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (step == '0) begin
              err_d = 1'b1;
            end else begin
              mode_d  = decode_mode(mode);
              sfreq_d = start_freq;
              efreq_d = stop_freq;
              tgt_d   = stop_freq;
              step_d  = step;
              dwell_d = dwell_eff;
              cnt_d   = dwell_eff - DWW'(1);
              dir_d   = (stop_freq >= start_freq);
              freq_d  = start_freq;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWW'(1);
          end else begin
            cnt_d = dwell_q - DWW'(1);
            if (!leg_end) begin
              freq_d = adv_nxt;
            end else begin
              done_d = 1'b1;
              case (mode_q)
                REPEAT: freq_d = sfreq_q;
                TRIANGLE: begin
                  dir_d  = ~dir_q;
                  tgt_d  = tgt_swap;
                  freq_d = turn_nxt;
                end
                default: state_d = IDLE;
              endcase
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign freq    = freq_q;
  assign busy    = (state_q == RUN);
  assign freq_en = (state_q == RUN);
  assign dir     = dir_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
